// File: rtl/arith_sched_pkg.sv
// Shared types and constants for the arith_sched mult/div peripheral.
// Optional IRQ support is enabled with ARITH_SCHED_IRQ_EN.
package arith_sched_pkg;

    localparam logic [4:0] OFF_A      = 5'h00;
    localparam logic [4:0] OFF_B      = 5'h04;
    localparam logic [4:0] OFF_CTRL   = 5'h08;
    localparam logic [4:0] OFF_RES_LO = 5'h0C;
    localparam logic [4:0] OFF_RES_HI = 5'h10;
    localparam logic [4:0] OFF_STATUS = 5'h14;

    localparam int ST_DONE = 0;
    localparam int ST_BUSY = 1;
    localparam int ST_PEND = 2;
    localparam int ST_IEN  = 3;

    localparam logic WIN_MUL = 1'b0;
    localparam logic WIN_DIV = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_WB
    } state_e;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } op_e;

endpackage

// File: rtl/arith_iter_engine.sv
// Bit-serial engine: shift-add multiply and restoring divide.
// One step per cycle, XLEN steps per operation.
module arith_iter_engine
    import arith_sched_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              step_i,
    input  logic              op_i,
    input  logic [XLEN-1:0]   a_i,
    input  logic [XLEN-1:0]   b_i,
    output logic [2*XLEN-1:0] res_o
);

    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   b_q;
    op_e               op_q;
    logic [XLEN:0]     add_sum;
    logic [XLEN:0]     trial;
    logic [XLEN-1:0]   diff;
    logic              ge;

    // acc holds {hi, lo}: mult keeps the multiplier in lo, div keeps
    // the remainder in hi and shifts quotient bits into lo.
    always_comb begin
        add_sum = {1'b0, acc_q[2*XLEN-1:XLEN]}
                + (acc_q[0] ? {1'b0, b_q} : '0);
        trial   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        ge      = (trial >= {1'b0, b_q});
        diff    = trial[XLEN-1:0] - b_q;
        acc_d   = acc_q;
        if (load_i) begin
            acc_d = {{XLEN{1'b0}}, a_i};
        end else if (step_i) begin
            if (op_q == OP_MUL) begin
                acc_d = {add_sum, acc_q[XLEN-1:1]};
            end else begin
                acc_d = {ge ? diff : trial[XLEN-1:0],
                         acc_q[XLEN-2:0], ge};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            b_q   <= '0;
            op_q  <= OP_MUL;
        end else begin
            acc_q <= acc_d;
            if (load_i) begin
                b_q  <= b_i;
                op_q <= op_e'(op_i);
            end
        end
    end

    assign res_o = acc_q;

endmodule

// File: rtl/arith_sched.sv
// Mult/div bus windows sharing one iterative engine, round-robin.
// Define ARITH_SCHED_IRQ_EN to add the completion irq output.
module arith_sched
    import arith_sched_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] d_in,
    input  logic            cs_mult,
    input  logic            cs_div,
    input  logic [4:0]      addr,
    input  logic            rd,
    input  logic            wr,
    output logic [XLEN-1:0] d_out
`ifdef ARITH_SCHED_IRQ_EN
   ,output logic            irq
`endif
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

    logic            sel;
    logic            wr_en;
    logic            rd_en;
    logic [XLEN-1:0] a_q [2];
    logic [XLEN-1:0] b_q [2];
    logic [XLEN-1:0] lo_q [2];
    logic [XLEN-1:0] hi_q [2];
    logic [1:0]      pend_q, busy_q, done_q;
    logic [1:0]      start_set, req_d;
    state_e          state_q;
    logic            gnt_q, gnt_d, last_q;
    logic [CW-1:0]   cnt_q;
    logic [2*XLEN-1:0] eng_res;
    logic [XLEN-1:0] status, rdata_d;
`ifdef ARITH_SCHED_IRQ_EN
    logic [1:0]      ien_q;
    logic            wb_q;
`endif

    // mult wins if both selects are ever asserted together
    assign sel   = cs_mult ? WIN_MUL : WIN_DIV;
    assign wr_en = (cs_mult | cs_div) & wr;
    assign rd_en = (cs_mult | cs_div) & rd;

    always_comb begin
        start_set = '0;
        if (wr_en && addr == OFF_CTRL && d_in[0]
            && !pend_q[sel] && !busy_q[sel]) begin
            start_set[sel] = 1'b1;
        end
        req_d = pend_q | start_set;
        if (req_d[0] && req_d[1]) gnt_d = ~last_q;
        else                      gnt_d = req_d[1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= '{default: '0};
            b_q <= '{default: '0};
`ifdef ARITH_SCHED_IRQ_EN
            ien_q <= '0;
`endif
        end else if (wr_en) begin
            if (addr == OFF_A) a_q[sel] <= d_in;
            if (addr == OFF_B) b_q[sel] <= d_in;
`ifdef ARITH_SCHED_IRQ_EN
            if (addr == OFF_CTRL) ien_q[sel] <= d_in[1];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            gnt_q   <= WIN_MUL;
            last_q  <= WIN_DIV;
            cnt_q   <= '0;
            pend_q  <= '0;
            busy_q  <= '0;
            done_q  <= '0;
            lo_q    <= '{default: '0};
            hi_q    <= '{default: '0};
`ifdef ARITH_SCHED_IRQ_EN
            wb_q    <= 1'b0;
            irq     <= 1'b0;
`endif
        end else begin
            pend_q <= pend_q | start_set;
            done_q <= done_q & ~start_set;
`ifdef ARITH_SCHED_IRQ_EN
            wb_q   <= (state_q == S_WB) && ien_q[gnt_q];
            irq    <= wb_q;
`endif
            unique case (state_q)
                S_IDLE: begin
                    if (|req_d) begin
                        gnt_q   <= gnt_d;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    pend_q[gnt_q] <= 1'b0;
                    busy_q[gnt_q] <= 1'b1;
                    cnt_q         <= '0;
                    state_q       <= S_RUN;
                end
                S_RUN: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) state_q <= S_WB;
                end
                S_WB: begin
                    lo_q[gnt_q]   <= eng_res[XLEN-1:0];
                    hi_q[gnt_q]   <= eng_res[2*XLEN-1:XLEN];
                    done_q[gnt_q] <= 1'b1;
                    busy_q[gnt_q] <= 1'b0;
                    last_q        <= gnt_q;
                    state_q       <= S_IDLE;
                end
            endcase
        end
    end

    arith_iter_engine #(
        .XLEN (XLEN)
    ) u_engine (
        .clk    (clk),
        .rst    (rst),
        .load_i (state_q == S_LOAD),
        .step_i (state_q == S_RUN),
        .op_i   (gnt_q),
        .a_i    (a_q[gnt_q]),
        .b_i    (b_q[gnt_q]),
        .res_o  (eng_res)
    );

    always_comb begin
        status          = '0;
        status[ST_DONE] = done_q[sel];
        status[ST_BUSY] = busy_q[sel];
        status[ST_PEND] = pend_q[sel];
`ifdef ARITH_SCHED_IRQ_EN
        status[ST_IEN]  = ien_q[sel];
`endif
        case (addr)
            OFF_A:      rdata_d = a_q[sel];
            OFF_B:      rdata_d = b_q[sel];
            OFF_RES_LO: rdata_d = lo_q[sel];
            OFF_RES_HI: rdata_d = hi_q[sel];
            OFF_STATUS: rdata_d = status;
            default:    rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)        d_out <= '0;
        else if (rd_en) d_out <= rdata_d;
    end

endmodule

// File: tb/tb_arith_sched.sv
// Scoreboard bench for arith_sched: bus reads push expected data,
// the read monitor pops and compares one cycle later.
module tb_arith_sched;
    import arith_sched_pkg::*;

    localparam logic WM = 1'b0;
    localparam logic WD = 1'b1;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] d_in;
    logic        cs_mult, cs_div;
    logic [4:0]  addr;
    logic        rd, wr;
    logic [31:0] d_out;
    logic        rd_pend = 1'b0;

    logic [31:0] exp_q [$];
    string       tag_q [$];
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    arith_sched #(
        .XLEN (32)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .d_in    (d_in),
        .cs_mult (cs_mult),
        .cs_div  (cs_div),
        .addr    (addr),
        .rd      (rd),
        .wr      (wr),
        .d_out   (d_out)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] expv);
        vectors++;
        if (got !== expv) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, expv);
        end
    endtask

    always @(posedge clk) rd_pend <= (cs_mult | cs_div) & rd & ~rst;

    always @(negedge clk) begin
        if (rd_pend) begin
            if (exp_q.size() != 0)
                check(tag_q.pop_front(), d_out, exp_q.pop_front());
            else
                check("sb_depth", 32'(exp_q.size()), 32'd1);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_wr(input logic win, input logic [4:0] off,
                          input logic [31:0] data);
        cs_mult = (win == WM);
        cs_div  = (win == WD);
        addr    = off;
        d_in    = data;
        wr      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cs_mult = 1'b0;
        cs_div  = 1'b0;
        wr      = 1'b0;
    endtask

    task automatic bus_rd(input logic win, input logic [4:0] off,
                          input logic [31:0] expv, input string tag);
        exp_q.push_back(expv);
        tag_q.push_back(tag);
        cs_mult = (win == WM);
        cs_div  = (win == WD);
        addr    = off;
        rd      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cs_mult = 1'b0;
        cs_div  = 1'b0;
        rd      = 1'b0;
    endtask

    task automatic set_ops(input logic win, input logic [31:0] a,
                           input logic [31:0] b);
        bus_wr(win, OFF_A, a);
        bus_wr(win, OFF_B, b);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; d_in = '0; cs_mult = 1'b0; cs_div = 1'b0;
        addr = '0; rd = 1'b0; wr = 1'b0;
        idle(3);
        rst = 1'b0;
        idle(1);

        bus_rd(WM, OFF_STATUS, 32'h0, "rst_m_status");
        bus_rd(WD, OFF_STATUS, 32'h0, "rst_d_status");
        bus_rd(WM, OFF_RES_LO, 32'h0, "rst_m_lo");
        bus_rd(WD, OFF_A,      32'h0, "rst_d_a");

        // basic multiply with edge-exact status timing
        set_ops(WM, 32'h0000_1234, 32'h0000_5678);
        bus_rd(WM, OFF_A, 32'h0000_1234, "m_a_rb");
        bus_wr(WM, OFF_CTRL, 32'h1);
        bus_rd(WM, OFF_STATUS, 32'h4, "m1_pend");
        idle(32);
        bus_rd(WM, OFF_STATUS, 32'h2, "m1_busy_k34");
        bus_rd(WM, OFF_STATUS, 32'h1, "m1_done_k35");
        bus_rd(WM, OFF_RES_LO, 32'h0626_0060, "m1_lo");
        bus_rd(WM, OFF_RES_HI, 32'h0, "m1_hi");
        bus_rd(WM, 5'h18, 32'h0, "unmapped");
        bus_wr(WM, OFF_RES_LO, 32'hDEAD_BEEF);
        bus_rd(WM, OFF_RES_LO, 32'h0626_0060, "ro_write");

        // divide, including divide by zero; CTRL bit1 has no effect
        set_ops(WD, 32'd100, 32'd7);
        bus_wr(WD, OFF_CTRL, 32'h3);
        idle(34);
        bus_rd(WD, OFF_STATUS, 32'h1, "d1_done");
        bus_rd(WD, OFF_RES_LO, 32'd14, "d1_quo");
        bus_rd(WD, OFF_RES_HI, 32'd2, "d1_rem");
        set_ops(WD, 32'd5, 32'd0);
        bus_wr(WD, OFF_CTRL, 32'h1);
        idle(34);
        bus_rd(WD, OFF_STATUS, 32'h1, "dz_done");
        bus_rd(WD, OFF_RES_LO, 32'hFFFF_FFFF, "dz_quo");
        bus_rd(WD, OFF_RES_HI, 32'd5, "dz_rem");

        set_ops(WM, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        bus_wr(WM, OFF_CTRL, 32'h1);
        idle(34);
        bus_rd(WM, OFF_STATUS, 32'h1, "mx_done");
        bus_rd(WM, OFF_RES_LO, 32'h0000_0001, "mx_lo");
        bus_rd(WM, OFF_RES_HI, 32'hFFFF_FFFE, "mx_hi");

        // contention: div queued behind an active mult
        set_ops(WM, 32'hDEAD_BEEF, 32'h10);
        set_ops(WD, 32'h1234_5678, 32'h100);
        bus_wr(WM, OFF_CTRL, 32'h1);
        idle(1);
        bus_wr(WD, OFF_CTRL, 32'h1);
        bus_rd(WD, OFF_STATUS, 32'h4, "c_d_pend");
        bus_rd(WM, OFF_STATUS, 32'h2, "c_m_busy");
        idle(30);
        bus_rd(WM, OFF_STATUS, 32'h1, "c_m_done");
        bus_rd(WD, OFF_STATUS, 32'h4, "c_d_still_pend");
        idle(32);
        bus_rd(WD, OFF_STATUS, 32'h2, "c_d_busy");
        bus_rd(WD, OFF_STATUS, 32'h1, "c_d_done");
        bus_rd(WM, OFF_RES_LO, 32'hEADB_EEF0, "c_m_lo");
        bus_rd(WM, OFF_RES_HI, 32'h0000_000D, "c_m_hi");
        bus_rd(WD, OFF_RES_LO, 32'h0012_3456, "c_d_quo");
        bus_rd(WD, OFF_RES_HI, 32'h0000_0078, "c_d_rem");

        // restarts and operand writes while pending/busy
        set_ops(WM, 32'd7, 32'd9);
        bus_wr(WM, OFF_CTRL, 32'h1);
        bus_wr(WM, OFF_CTRL, 32'h1);
        idle(1);
        bus_wr(WM, OFF_B, 32'd100);
        bus_wr(WM, OFF_CTRL, 32'h1);
        idle(30);
        bus_rd(WM, OFF_STATUS, 32'h1, "bz_done");
        bus_rd(WM, OFF_RES_LO, 32'd63, "bz_lo");
        idle(5);
        bus_rd(WM, OFF_STATUS, 32'h1, "bz_no_extra");
        bus_rd(WM, OFF_B, 32'd100, "bz_b_rb");
        bus_rd(WM, OFF_RES_LO, 32'd63, "bz_lo_again");

        // reset in the middle of RUN
        set_ops(WM, 32'h1000, 32'h3);
        bus_wr(WM, OFF_CTRL, 32'h1);
        idle(9);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        bus_rd(WM, OFF_STATUS, 32'h0, "r_m_status");
        bus_rd(WD, OFF_STATUS, 32'h0, "r_d_status");
        bus_rd(WM, OFF_RES_LO, 32'h0, "r_m_lo");
        bus_rd(WD, OFF_RES_HI, 32'h0, "r_d_hi");
        bus_rd(WM, OFF_A, 32'h0, "r_m_a");
        set_ops(WM, 32'h1000, 32'h3);
        bus_wr(WM, OFF_CTRL, 32'h1);
        idle(33);
        bus_rd(WM, OFF_STATUS, 32'h2, "r2_busy");
        bus_rd(WM, OFF_STATUS, 32'h1, "r2_done");
        bus_rd(WM, OFF_RES_LO, 32'h3000, "r2_lo");
        bus_rd(WM, OFF_RES_HI, 32'h0, "r2_hi");

        idle(2);
        check("sb_left", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
